// File: rtl/time_set_if.sv
// Key/tick inputs and set-mode outputs exchanged between the keypad/tick source
// and the time-set sequencer.
interface time_set_if;
  logic       sec_tick;
  logic       mode_n;
  logic       add_n;
  logic       deduct_n;
  logic       run_en;
  logic [1:0] sel;
  logic       inc_hr;
  logic       dec_hr;
  logic       inc_min;
  logic       dec_min;
  logic       clr_sec;
  logic       blink;

  modport master (
    output sec_tick, mode_n, add_n, deduct_n,
    input  run_en, sel, inc_hr, dec_hr, inc_min, dec_min, clr_sec, blink
  );

  modport slave (
    input  sec_tick, mode_n, add_n, deduct_n,
    output run_en, sel, inc_hr, dec_hr, inc_min, dec_min, clr_sec, blink
  );
endinterface

// File: rtl/time_set_controller.sv
// Mode/set sequencer for the h/m/s clock: key debounce, RUN/SET_HR/SET_MIN/SET_SEC
// stepping, inc/dec/clear strobes with auto-repeat, set timeout and field blink.
module time_set_controller #(
  parameter int unsigned DEBOUNCE_CYC  = 20,
  parameter int unsigned REPEAT_START  = 200,
  parameter int unsigned REPEAT_PERIOD = 50,
  parameter int unsigned TIMEOUT_S     = 30
) (
  input logic        clk,
  input logic        rst_n,
  time_set_if.slave  bus
);

  localparam int unsigned NKEY     = 3;
  localparam int unsigned KEY_MODE = 0;
  localparam int unsigned KEY_ADD  = 1;
  localparam int unsigned KEY_DED  = 2;
  localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned RP_MAX   = (REPEAT_START > REPEAT_PERIOD) ? REPEAT_START : REPEAT_PERIOD;
  localparam int unsigned RP_W     = $clog2(RP_MAX + 1);
  localparam int unsigned TO_W     = $clog2(TIMEOUT_S + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_t;

  state_t state, state_next;

  logic [NKEY-1:0] raw_c;
  logic [NKEY-1:0] sync1, sync2, lvl, lvl_q;
  logic [DB_W-1:0] db_cnt [NKEY];

  logic            rep_on, rep_key, rep_first;
  logic [RP_W-1:0] rep_cnt;
  logic [TO_W-1:0] to_cnt;

  logic       run_en_d, blink_d, strobe_d;
  logic [1:0] sel_d;
  logic       inc_hr_d, dec_hr_d, inc_min_d, dec_min_d, clr_sec_d;

  assign raw_c = {bus.deduct_n, bus.add_n, bus.mode_n};

  // Two-flop synchronizer, then a level only flips after DEBOUNCE_CYC equal samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      lvl   <= '1;
      lvl_q <= '1;
      for (int i = 0; i < NKEY; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw_c;
      sync2 <= sync1;
      lvl_q <= lvl;
      for (int i = 0; i < NKEY; i++) begin
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          lvl[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  logic [NKEY-1:0] press_c;
  logic mode_p, add_acc, ded_acc, add_low, ded_low, both_low, key_low;
  logic rep_fire_c, timeout_c, set_adj_c;

  assign press_c    = lvl_q & ~lvl;
  assign mode_p     = press_c[KEY_MODE];
  // Simultaneous add+deduct presses cancel each other.
  assign add_acc    = press_c[KEY_ADD] & ~press_c[KEY_DED];
  assign ded_acc    = press_c[KEY_DED] & ~press_c[KEY_ADD];
  assign add_low    = ~lvl[KEY_ADD];
  assign ded_low    = ~lvl[KEY_DED];
  assign both_low   = add_low & ded_low;
  assign key_low    = rep_key ? ded_low : add_low;
  assign set_adj_c  = (state == SET_HR) || (state == SET_MIN);
  assign timeout_c  = (state != RUN) && (to_cnt == TO_W'(TIMEOUT_S));
  assign rep_fire_c = rep_on && key_low && !both_low &&
                      (rep_cnt == (rep_first ? RP_W'(REPEAT_START - 1) : RP_W'(REPEAT_PERIOD - 1)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // Next state: mode press advances, timeout falls back to RUN
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (mode_p) state_next = SET_HR;
      SET_HR:  if (mode_p) state_next = SET_MIN; else if (timeout_c) state_next = RUN;
      SET_MIN: if (mode_p) state_next = SET_SEC; else if (timeout_c) state_next = RUN;
      SET_SEC: if (mode_p || timeout_c) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Output decode: next values of the registered outputs
  always_comb begin
    inc_hr_d  = 1'b0;
    dec_hr_d  = 1'b0;
    inc_min_d = 1'b0;
    dec_min_d = 1'b0;
    clr_sec_d = 1'b0;
    run_en_d  = (state_next == RUN);
    sel_d     = state_next;
    if (!mode_p && !timeout_c) begin
      case (state)
        SET_HR: begin
          inc_hr_d = add_acc | (rep_fire_c & ~rep_key);
          dec_hr_d = ded_acc | (rep_fire_c &  rep_key);
        end
        SET_MIN: begin
          inc_min_d = add_acc | (rep_fire_c & ~rep_key);
          dec_min_d = ded_acc | (rep_fire_c &  rep_key);
        end
        SET_SEC: clr_sec_d = add_acc | ded_acc;
        default: ;
      endcase
    end
    strobe_d = inc_hr_d | dec_hr_d | inc_min_d | dec_min_d | clr_sec_d;
    if ((state_next == RUN) || (state_next != state) || strobe_d) blink_d = 1'b0;
    else if (bus.sec_tick)                                        blink_d = ~bus.blink;
    else                                                          blink_d = bus.blink;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.run_en  <= 1'b1;
      bus.sel     <= 2'd0;
      bus.inc_hr  <= 1'b0;
      bus.dec_hr  <= 1'b0;
      bus.inc_min <= 1'b0;
      bus.dec_min <= 1'b0;
      bus.clr_sec <= 1'b0;
      bus.blink   <= 1'b0;
    end else begin
      bus.run_en  <= run_en_d;
      bus.sel     <= sel_d;
      bus.inc_hr  <= inc_hr_d;
      bus.dec_hr  <= dec_hr_d;
      bus.inc_min <= inc_min_d;
      bus.dec_min <= dec_min_d;
      bus.clr_sec <= clr_sec_d;
      bus.blink   <= blink_d;
    end
  end

  // Timeout and auto-repeat bookkeeping; any state change cancels repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt    <= '0;
      rep_on    <= 1'b0;
      rep_key   <= 1'b0;
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else begin
      if ((state_next != state) || strobe_d)
        to_cnt <= '0;
      else if (bus.sec_tick && (state != RUN) && (to_cnt != TO_W'(TIMEOUT_S)))
        to_cnt <= to_cnt + TO_W'(1);

      if (state_next != state) begin
        rep_on <= 1'b0;
      end else if (set_adj_c && (add_acc || ded_acc)) begin
        rep_on    <= 1'b1;
        rep_key   <= ded_acc;
        rep_first <= 1'b1;
        rep_cnt   <= '0;
      end else if (rep_on) begin
        if (!key_low) begin
          rep_on <= 1'b0;
        end else if (!both_low) begin
          if (rep_fire_c) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
          end else begin
            rep_cnt <= rep_cnt + RP_W'(1);
          end
        end
      end
    end
  end

endmodule
